// File: rtl/cae_inst_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cae_inst_sched_pkg
//  Description : Shared types and widths for the CAE instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cae_inst_sched_pkg;

  localparam int CAEP_W = 5;
  localparam int IDX_W  = 18;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_RET    = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WAIT   = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cae_inst_sched_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : cae_inst_sched_wdog
//  Description : CAEP watchdog counter. Counts while enabled, flags expiry
//                on the TMO_CYCLES-th enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cae_inst_sched_wdog #(
  parameter int TMO_CYCLES = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TMO_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Free-running count of enabled cycles, restarted by clr_i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == CW'(TMO_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/cae_inst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cae_inst_sched
//  Description : Sequences decoder strobes into AEG register-file accesses
//                or CAEP dispatches, stalling the host until completion.
//                Define CAE_INST_SCHED_WDOG_EN to bound the CAEP wait with a
//                watchdog (err_timeout); otherwise the wait is unbounded.
//  Revision    : 1.0 - initial release
// ============================================================================
module cae_inst_sched
  import cae_inst_sched_pkg::*;
#(
  parameter int NUM_AEG    = 64,
  parameter int AEG_AW     = $clog2(NUM_AEG),
  parameter int RD_LAT     = 1,
  parameter int TMO_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_val,
  input  logic [CAEP_W-1:0] inst_caep,
  input  logic              inst_aeg_wr,
  input  logic              inst_aeg_rd,
  input  logic [IDX_W-1:0]  inst_aeg_idx,
  input  logic              err_unimpl,
  input  logic [DATA_W-1:0] cae_data,
  output logic              aeg_we,
  output logic              aeg_re,
  output logic [AEG_AW-1:0] aeg_addr,
  output logic [DATA_W-1:0] aeg_wdata,
  input  logic [DATA_W-1:0] aeg_rdata,
  output logic              exec_start,
  output logic [CAEP_W-1:0] exec_caep,
  input  logic              exec_done,
  output logic              cae_ret_data_vld,
  output logic [DATA_W-1:0] cae_ret_data,
  output logic              cae_stall,
  output logic              cae_idle,
  input  logic              err_clr,
  output logic              err_aeg_range,
  output logic              err_unimpl_st,
  output logic              err_busy,
  output logic              err_timeout
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic              aeg_we_q, aeg_re_q, exec_start_q, ret_vld_q;
  logic              stall_q, idle_q, rd_ok_q;
  logic [AEG_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ret_data_q;
  logic [CAEP_W-1:0] caep_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic              err_range_q, err_unimpl_q, err_busy_q;

  logic w_idx_ok, w_rd_last, w_strobe, w_wdog_expired;
  logic w_set_range, w_set_unimpl, w_set_busy, w_set_tmo;

`ifdef CAE_INST_SCHED_WDOG_EN
  logic err_tmo_q;

  cae_inst_sched_wdog #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q != ST_WAIT),
    .en_i      (state_q == ST_WAIT),
    .expired_o (w_wdog_expired)
  );

  // Sticky timeout flag; a new expiry in the clear cycle still sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_tmo_q <= 1'b0;
    else       err_tmo_q <= w_set_tmo | (err_tmo_q & ~err_clr);
  end

  assign err_timeout = err_tmo_q;
`else
  logic w_unused_tmo;
  assign w_unused_tmo   = (TMO_CYCLES != 0);
  assign w_wdog_expired = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  // Next-state selection and error-set conditions.
  always_comb begin
    state_d      = state_q;
    w_idx_ok     = (inst_aeg_idx < IDX_W'(NUM_AEG));
    w_rd_last    = (rd_cnt_q == CNT_W'(RD_LAT - 1));
    w_strobe     = inst_val | inst_aeg_wr | inst_aeg_rd | err_unimpl;
    w_set_unimpl = (state_q == ST_IDLE) && err_unimpl;
    w_set_range  = (state_q == ST_IDLE) && !err_unimpl &&
                   (inst_aeg_wr || inst_aeg_rd) && !w_idx_ok;
    w_set_busy   = (state_q != ST_IDLE) && w_strobe;
    w_set_tmo    = (state_q == ST_WAIT) && !exec_done && w_wdog_expired;
    case (state_q)
      ST_IDLE: begin
        if (err_unimpl)       state_d = ST_IDLE;
        else if (inst_aeg_wr) state_d = ST_WR;
        else if (inst_aeg_rd) state_d = ST_RD;
        else if (inst_val)    state_d = ST_EXEC;
      end
      ST_WR:     state_d = ST_IDLE;
      ST_RD:     state_d = rd_ok_q ? ST_RDWAIT : ST_RET;
      ST_RDWAIT: if (w_rd_last) state_d = ST_RET;
      ST_RET:    state_d = ST_IDLE;
      ST_EXEC:   state_d = ST_WAIT;
      ST_WAIT:   if (exec_done || w_wdog_expired) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register plus all registered sequencer outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      aeg_we_q     <= 1'b0;
      aeg_re_q     <= 1'b0;
      exec_start_q <= 1'b0;
      ret_vld_q    <= 1'b0;
      stall_q      <= 1'b0;
      idle_q       <= 1'b1;
      rd_ok_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ret_data_q   <= '0;
      caep_q       <= '0;
      rd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      stall_q      <= (state_d != ST_IDLE);
      idle_q       <= (state_d == ST_IDLE);
      aeg_we_q     <= (state_d == ST_WR) && w_idx_ok;
      aeg_re_q     <= (state_d == ST_RD) && w_idx_ok;
      exec_start_q <= (state_d == ST_EXEC);
      ret_vld_q    <= (state_d == ST_RET);
      if (state_d == ST_WR || state_d == ST_RD) begin
        addr_q  <= inst_aeg_idx[AEG_AW-1:0];
        rd_ok_q <= w_idx_ok;
      end
      if (state_d == ST_WR)   wdata_q <= cae_data;
      if (state_d == ST_EXEC) caep_q  <= inst_caep;
      if (state_q == ST_RD) begin
        rd_cnt_q <= '0;
        // Out-of-range reads bypass the register file and return zero.
        if (!rd_ok_q) ret_data_q <= '0;
      end else if (state_q == ST_RDWAIT) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (w_rd_last) ret_data_q <= aeg_rdata;
      end
    end
  end

  // Sticky error flags; a set coinciding with err_clr takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_range_q  <= 1'b0;
      err_unimpl_q <= 1'b0;
      err_busy_q   <= 1'b0;
    end else begin
      err_range_q  <= w_set_range  | (err_range_q  & ~err_clr);
      err_unimpl_q <= w_set_unimpl | (err_unimpl_q & ~err_clr);
      err_busy_q   <= w_set_busy   | (err_busy_q   & ~err_clr);
    end
  end

  assign aeg_we           = aeg_we_q;
  assign aeg_re           = aeg_re_q;
  assign aeg_addr         = addr_q;
  assign aeg_wdata        = wdata_q;
  assign exec_start       = exec_start_q;
  assign exec_caep        = caep_q;
  assign cae_ret_data_vld = ret_vld_q;
  assign cae_ret_data     = ret_data_q;
  assign cae_stall        = stall_q;
  assign cae_idle         = idle_q;
  assign err_aeg_range    = err_range_q;
  assign err_unimpl_st    = err_unimpl_q;
  assign err_busy         = err_busy_q;

endmodule
`default_nettype wire

// File: doc/cae_inst_sched.md
# cae_inst_sched

Sequencer between the CAE instruction decoder and the AEG register file / personality execution engine. It takes the decoder's one-cycle strobes (AEG write, AEG read, CAEP dispatch, unimplemented), performs the AEG access or starts the CAEP, and holds the host off with stall until the operation completes. It returns read data to the host, raises idle, and keeps sticky error flags for the error-reporting block.

## Interface
Parameters:
- NUM_AEG, 64: number of implemented AEG registers; indices >= NUM_AEG are out of range.
- AEG_AW, $clog2(NUM_AEG): AEG address width.
- RD_LAT, 1: AEG register-file read latency in cycles (>= 1).
- TMO_CYCLES, 1048576: CAEP watchdog limit (only with the watchdog macro).

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- inst_val  in  1  CAEP dispatch strobe from the decoder.
- inst_caep  in  5  CAEP opcode, valid with inst_val.
- inst_aeg_wr  in  1  AEG write strobe.
- inst_aeg_rd  in  1  AEG read strobe.
- inst_aeg_idx  in  18  AEG index, valid with wr/rd strobes.
- err_unimpl  in  1  unimplemented-instruction strobe.
- cae_data  in  64  write data, aligned with inst_aeg_wr.
- aeg_we  out  1  register-file write enable.
- aeg_re  out  1  register-file read enable.
- aeg_addr  out  AEG_AW  register-file address.
- aeg_wdata  out  64  register-file write data.
- aeg_rdata  in  64  read data, valid RD_LAT cycles after aeg_re.
- exec_start  out  1  one-cycle CAEP start pulse.
- exec_caep  out  5  CAEP opcode, held from start until done.
- exec_done  in  1  personality completion pulse.
- cae_ret_data_vld  out  1  one-cycle read-return strobe.
- cae_ret_data  out  64  read-return data.
- cae_stall  out  1  host must not issue instructions.
- cae_idle  out  1  no operation in flight.
- err_clr  in  1  clears all sticky errors.
- err_aeg_range  out  1  sticky: AEG index out of range.
- err_unimpl_st  out  1  sticky: unimplemented instruction.
- err_busy  out  1  sticky: strobe arrived while not IDLE.
- err_timeout  out  1  sticky: watchdog expiry (0 when the watchdog is compiled out).

## Operation
- States: IDLE, WR, RD, RDWAIT, RET, EXEC, WAIT. All outputs are registered.
- IDLE: a strobe at cycle T is captured. Priority is err_unimpl > aeg_wr > aeg_rd > inst_val.
  - err_unimpl: set err_unimpl_st. Stay in IDLE.
  - aeg_wr: go to WR.
  - aeg_rd: go to RD.
  - inst_val: go to EXEC.
- WR: drive aeg_we=1, aeg_addr=idx[AEG_AW-1:0], aeg_wdata=captured cae_data. Then go to IDLE.
- RD: drive aeg_re=1. Then go to RDWAIT, counting RD_LAT cycles. Capture aeg_rdata on the last count, then go to RET.
- RET: cae_ret_data_vld=1 with the captured data. Then go to IDLE.
- Out-of-range index (idx >= NUM_AEG):
  - Set err_aeg_range.
  - A write suppresses aeg_we and still passes through WR.
  - A read suppresses aeg_re, skips RDWAIT, and returns 0 in RET.
- EXEC: exec_start=1 and exec_caep latched. Then go to WAIT.
- WAIT: hold until exec_done=1, then go to IDLE. exec_done in any other state is ignored.
- Strobes arriving outside IDLE are dropped and set err_busy.
- Sticky errors:
  - Cleared by err_clr.
  - A set in the same cycle as err_clr wins.
  - Errors do not affect sequencing.
- cae_stall = (state != IDLE). cae_idle = (state == IDLE).

## Timing
- Reset: state IDLE, cae_idle=1, and every other output 0 (including exec_caep, aeg_addr, aeg_wdata, cae_ret_data).
- Write: strobe at T → aeg_we at T+1 → idle at T+2.
- Read: strobe at T → aeg_re at T+1 → data sampled at T+1+RD_LAT → cae_ret_data_vld at T+2+RD_LAT → idle the cycle after.
- Exec: strobe at T → exec_start at T+1 → exec_done sampled from T+2 onward. Done at D → idle at D+1.
- Stall rises at T+1, because the strobe cycle itself is already accepted.
- Reset mid-operation: immediate return to IDLE. No exec_start or ret strobe is replayed.

## Configuration
- CAE_INST_SCHED_WDOG_EN defined:
  - A counter runs in WAIT.
  - After TMO_CYCLES cycles without exec_done, set err_timeout and go to IDLE.
  - A late exec_done is then ignored.
- Not defined: WAIT has no bound, err_timeout is tied to 0, and TMO_CYCLES is unused.

## Structure
- Package cae_inst_sched_pkg holds:
  - the state enum;
  - the CAEP width (5), AEG index width (18) and data width (64) constants.
- Sub-module cae_inst_sched_wdog contains the watchdog counter (clear, enable, expired). It is instantiated only under CAE_INST_SCHED_WDOG_EN.

## Test plan
- Write then read back: aeg_wr with idx=5, data=0xDEADBEEF_CAFEF00D, then aeg_rd with idx=5 → aeg_we at T+1 with addr 5; with RD_LAT=1, cae_ret_data_vld at T+3 with the same data; stall high for exactly 3 cycles.
- Out-of-range read with idx=64 → no aeg_re, ret_vld with data 0, err_aeg_range=1; err_clr → 0.
- CAEP 0x03 dispatch, exec_done after 10 cycles → exec_start single pulse, exec_caep=3 held, idle one cycle after done.
- Busy: aeg_rd issued during WAIT → dropped and err_busy=1. err_clr together with a new busy strobe → err_busy stays 1.
- err_unimpl together with aeg_wr → no aeg_we, err_unimpl_st=1, no stall.
- Watchdog (macro on, TMO_CYCLES=16): no exec_done → err_timeout at start+17 and back to IDLE. Reset asserted mid-WAIT → all outputs at reset values asynchronously.
